// File: rtl/adat_frame_deframer.sv
// -----------------------------------------------------------------------------
// adat_frame_deframer
//
// Recovers ADAT frames from the decoded bit stream of the NRZI phase-lock
// decoder. A frame is a SYNC_ZEROS-long zero run terminated by a '1', a 4-bit
// user field plus separator, then NUM_CH samples of SAMPLE_W bits, each sent
// MSB-first as SAMPLE_W/4 nibbles that are each followed by a '1' separator.
// One sample per channel per frame is emitted to the downstream buffer.
//
// Optional feature: define ADAT_ERR_COUNT_EN to add err_count_o, a saturating
// 16-bit count of frame_error_o pulses that only rst_i clears.
//
// Ports
//   clk_x4_i        in   4x bit clock, the only clock of the block
//   rst_i           in   asynchronous active-high reset
//   bit_tick_ni     in   active-low bit strobe; a bit is taken when it is 0
//   data_i          in   decoded bit
//   valid_i         in   decoder is synced, data_i is meaningful
//   sample_o        out  last completed sample, MSB = first received bit
//   channel_o       out  channel index of sample_o
//   sample_valid_o  out  one-cycle pulse, sample_o/channel_o are new
//   user_bits_o     out  user bits of the current frame, first received in [3]
//   frame_start_o   out  one-cycle pulse when a sync terminator is accepted
//   locked_o        out  a complete error-free frame has been seen since hunt
//   frame_error_o   out  one-cycle pulse on any framing error
//   err_count_o     out  (ADAT_ERR_COUNT_EN only) saturating error count
// -----------------------------------------------------------------------------
module adat_frame_deframer #(
  parameter int SYNC_ZEROS = 10,
  parameter int NUM_CH     = 8,
  parameter int SAMPLE_W   = 24
) (
  input  logic                clk_x4_i,
  input  logic                rst_i,
  input  logic                bit_tick_ni,
  input  logic                data_i,
  input  logic                valid_i,
  output logic [SAMPLE_W-1:0] sample_o,
  output logic [2:0]          channel_o,
  output logic                sample_valid_o,
  output logic [3:0]          user_bits_o,
  output logic                frame_start_o,
  output logic                locked_o,
  output logic                frame_error_o
`ifdef ADAT_ERR_COUNT_EN
  ,
  output logic [15:0]         err_count_o
`endif
);

  localparam int         NIBS      = SAMPLE_W / 4;
  localparam int         DATA_BITS = 5 * NIBS * NUM_CH;
  localparam logic [3:0] SYNC_Z    = 4'(SYNC_ZEROS);
  localparam logic [7:0] DATA_LAST = 8'(DATA_BITS - 1);
  localparam logic [2:0] NIB_LAST  = 3'(NIBS - 1);

  typedef enum logic [1:0] {StHunt, StUser, StData, StSync} state_t;

  state_t              state;
  state_t              state_d;
  logic                accept;
  logic [3:0]          zero_cnt;
  logic [7:0]          bit_cnt;
  logic [2:0]          slot;
  logic [2:0]          nib;
  logic [2:0]          ch;
  logic [SAMPLE_W-1:0] sample_sr;
  logic [3:0]          user_sr;

  logic                err_ev;
  logic                fs_ev;
  logic                lock_ev;
  logic                samp_ev;
  logic                user_ev;
  logic                is_sep;

  assign accept = ~bit_tick_ni;
  // Position 4 of every 5-bit group in the data field is the separator.
  assign is_sep = (slot == 3'd4);

  // State register
  always_ff @(posedge clk_x4_i or posedge rst_i) begin
    if (rst_i) state <= StHunt;
    else       state <= state_d;
  end

  // Next-state logic. Every path back to StHunt from another state is an
  // error; the output logic relies on that.
  always_comb begin
    state_d = state;
    if (accept) begin
      case (state)
        StHunt: begin
          if (valid_i && data_i && (zero_cnt == SYNC_Z)) state_d = StUser;
        end
        StUser: begin
          if (!valid_i)                state_d = StHunt;
          else if (bit_cnt == 8'd4)    state_d = data_i ? StData : StHunt;
        end
        StData: begin
          if (!valid_i || (is_sep && !data_i)) state_d = StHunt;
          else if (bit_cnt == DATA_LAST)       state_d = StSync;
        end
        StSync: begin
          if (!valid_i)                 state_d = StHunt;
          else if (data_i)              state_d = (zero_cnt == SYNC_Z) ? StUser : StHunt;
          else if (zero_cnt == SYNC_Z)  state_d = StHunt;  // run would reach SYNC_ZEROS+1
        end
        default: state_d = StHunt;
      endcase
    end
  end

  // Output event decode
  always_comb begin
    err_ev  = accept && (state != StHunt) && (state_d == StHunt);
    fs_ev   = accept && (state != StUser) && (state_d == StUser);
    lock_ev = fs_ev && (state == StSync);
    user_ev = accept && (state == StUser) && (state_d == StData);
    samp_ev = accept && (state == StData) && valid_i && is_sep && data_i &&
              (nib == NIB_LAST);
  end

  // Bit counters. zero_cnt follows the same rule in every state, so the bit
  // that causes an error is already counted the way StHunt counts it.
  always_ff @(posedge clk_x4_i or posedge rst_i) begin
    if (rst_i) begin
      zero_cnt <= '0;
      bit_cnt  <= '0;
      slot     <= '0;
      nib      <= '0;
      ch       <= '0;
    end else if (accept) begin
      if (!valid_i || data_i)    zero_cnt <= '0;
      else if (zero_cnt != 4'hF) zero_cnt <= zero_cnt + 4'd1;

      if (state_d != state) bit_cnt <= '0;
      else                  bit_cnt <= bit_cnt + 8'd1;

      if ((state != StData) || (state_d != StData)) begin
        slot <= '0;
        nib  <= '0;
        ch   <= '0;
      end else if (is_sep) begin
        slot <= '0;
        if (nib == NIB_LAST) begin
          nib <= '0;
          ch  <= ch + 3'd1;
        end else begin
          nib <= nib + 3'd1;
        end
      end else begin
        slot <= slot + 3'd1;
      end
    end
  end

  // Shift registers hold payload only and need no reset.
  always_ff @(posedge clk_x4_i) begin
    if (accept && (state == StData) && !is_sep)
      sample_sr <= {sample_sr[SAMPLE_W-2:0], data_i};
    if (accept && (state == StUser) && (bit_cnt != 8'd4))
      user_sr <= {user_sr[2:0], data_i};
  end

  // Registered outputs
  always_ff @(posedge clk_x4_i or posedge rst_i) begin
    if (rst_i) begin
      sample_o       <= '0;
      channel_o      <= '0;
      sample_valid_o <= 1'b0;
      user_bits_o    <= '0;
      frame_start_o  <= 1'b0;
      locked_o       <= 1'b0;
      frame_error_o  <= 1'b0;
    end else begin
      sample_valid_o <= samp_ev;
      frame_start_o  <= fs_ev;
      frame_error_o  <= err_ev;
      if (samp_ev) begin
        sample_o  <= sample_sr;
        channel_o <= ch;
      end
      if (user_ev) user_bits_o <= user_sr;
      if (err_ev)       locked_o <= 1'b0;
      else if (lock_ev) locked_o <= 1'b1;
    end
  end

`ifdef ADAT_ERR_COUNT_EN
  logic [15:0] err_cnt;

  always_ff @(posedge clk_x4_i or posedge rst_i) begin
    if (rst_i)                             err_cnt <= '0;
    else if (err_ev && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
  end

  assign err_count_o = err_cnt;
`endif

endmodule

// File: tb/tb_adat_frame_deframer.sv
// -----------------------------------------------------------------------------
// tb_adat_frame_deframer
//
// Directed bench for adat_frame_deframer: clean frames, separator fault,
// wrong sync lengths, valid_i drops, asynchronous reset mid-frame and, when
// ADAT_ERR_COUNT_EN is defined, the saturating error counter.
// -----------------------------------------------------------------------------
module tb_adat_frame_deframer;

  logic        clk_x4_i;
  logic        rst_i;
  logic        bit_tick_ni;
  logic        data_i;
  logic        valid_i;
  logic [23:0] sample_o;
  logic [2:0]  channel_o;
  logic        sample_valid_o;
  logic [3:0]  user_bits_o;
  logic        frame_start_o;
  logic        locked_o;
  logic        frame_error_o;
`ifdef ADAT_ERR_COUNT_EN
  logic [15:0] err_count_o;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n_fs     = 0;
  int n_fe     = 0;
  logic [26:0] samp_q[$];
  logic        lock_fs[$];

  adat_frame_deframer dut (
    .clk_x4_i       (clk_x4_i),
    .rst_i          (rst_i),
    .bit_tick_ni    (bit_tick_ni),
    .data_i         (data_i),
    .valid_i        (valid_i),
    .sample_o       (sample_o),
    .channel_o      (channel_o),
    .sample_valid_o (sample_valid_o),
    .user_bits_o    (user_bits_o),
    .frame_start_o  (frame_start_o),
    .locked_o       (locked_o),
    .frame_error_o  (frame_error_o)
`ifdef ADAT_ERR_COUNT_EN
    ,
    .err_count_o    (err_count_o)
`endif
  );

  initial clk_x4_i = 1'b0;
  always #5 clk_x4_i = ~clk_x4_i;

  // Record pulses and samples away from the active edge.
  always @(negedge clk_x4_i) begin
    if (sample_valid_o) samp_q.push_back({channel_o, sample_o});
    if (frame_start_o) begin
      n_fs++;
      lock_fs.push_back(locked_o);
    end
    if (frame_error_o) n_fe++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [26:0] exp_samp(input int c);
    return {3'(c), 24'h100000 + 24'(c)};
  endfunction

  task automatic send_bit(input logic d, input logic v);
    repeat (3) @(posedge clk_x4_i);
    #1;
    bit_tick_ni = 1'b0;
    data_i      = d;
    valid_i     = v;
    @(posedge clk_x4_i);
    #1;
    bit_tick_ni = 1'b1;
  endtask

  task automatic send_sync(input int nz);
    for (int i = 0; i < nz; i++) send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
  endtask

  // kind: 0 clean, 1 zero separator after nibble pos, 2 valid_i low at bit pos,
  // 3 stop after pos bits.
  task automatic send_channel(input logic [23:0] s, input int kind, input int pos);
    for (int k = 0; k < 6; k++) begin
      for (int b = 0; b < 4; b++) begin
        if (kind == 3 && (k * 5 + b) >= pos) return;
        send_bit(s[23 - 4 * k - b], !(kind == 2 && (k * 5 + b) == pos));
      end
      if (kind == 3 && (k * 5 + 4) >= pos) return;
      send_bit(!(kind == 1 && k == pos), !(kind == 2 && (k * 5 + 4) == pos));
    end
  endtask

  task automatic send_body(input logic [3:0] u, input int fch, input int kind, input int pos);
    for (int i = 3; i >= 0; i--) send_bit(u[i], 1'b1);
    send_bit(1'b1, 1'b1);
    for (int c = 0; c < 8; c++) begin
      if (c == fch) begin
        send_channel(24'h100000 + 24'(c), kind, pos);
        if (kind == 3) return;
      end else begin
        send_channel(24'h100000 + 24'(c), 0, 0);
      end
    end
  endtask

  task automatic settle();
    repeat (2) @(negedge clk_x4_i);
  endtask

  task automatic chk_samples(input int start, input int n);
    for (int i = 0; i < n; i++)
      chk($sformatf("sample[%0d]", start + i), 32'(samp_q[start + i]), 32'(exp_samp(i)));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".sample_o"},       32'(sample_o),       32'h0);
    chk({tag, ".channel_o"},      32'(channel_o),      32'h0);
    chk({tag, ".sample_valid_o"}, 32'(sample_valid_o), 32'h0);
    chk({tag, ".user_bits_o"},    32'(user_bits_o),    32'h0);
    chk({tag, ".frame_start_o"},  32'(frame_start_o),  32'h0);
    chk({tag, ".locked_o"},       32'(locked_o),       32'h0);
    chk({tag, ".frame_error_o"},  32'(frame_error_o),  32'h0);
  endtask

  initial begin
    rst_i       = 1'b1;
    bit_tick_ni = 1'b1;
    data_i      = 1'b0;
    valid_i     = 1'b0;
    repeat (3) @(posedge clk_x4_i);
    #1;
    chk_zero("reset");
`ifdef ADAT_ERR_COUNT_EN
    chk("reset.err_count_o", 32'(err_count_o), 32'h0);
`endif
    rst_i = 1'b0;

    // Clean frames
    for (int f = 0; f < 3; f++) begin
      send_sync(10);
      send_body(4'hA, -1, 0, 0);
    end
    settle();
    chk("clean.frame_starts", n_fs, 3);
    chk("clean.errors", n_fe, 0);
    chk("clean.sample_count", samp_q.size(), 24);
    for (int f = 0; f < 3; f++) chk_samples(f * 8, 8);
    chk("clean.lock_at_fs1", 32'(lock_fs[0]), 0);
    chk("clean.lock_at_fs2", 32'(lock_fs[1]), 1);
    chk("clean.lock_at_fs3", 32'(lock_fs[2]), 1);
    chk("clean.locked", 32'(locked_o), 1);
    chk("clean.user_bits", 32'(user_bits_o), 32'hA);

    // Separator after ch3 nibble 2 forced to 0
    send_sync(10);
    send_body(4'hA, 3, 1, 2);
    settle();
    chk("sep.errors", n_fe, 1);
    chk("sep.locked", 32'(locked_o), 0);
    chk("sep.sample_count", samp_q.size(), 27);
    chk_samples(24, 3);
    send_sync(10);
    settle();
    chk("sep.relock_fs", n_fs, 5);
    chk("sep.relock_lock0", 32'(lock_fs[4]), 0);
    send_body(4'hA, -1, 0, 0);
    send_sync(10);
    settle();
    chk("sep.relock_lock1", 32'(lock_fs[5]), 1);
    chk("sep.locked_again", 32'(locked_o), 1);
    send_body(4'hA, -1, 0, 0);
    settle();
    chk("sep.sample_count2", samp_q.size(), 43);

    // Sync length faults
    send_sync(9);
    settle();
    chk("sync9.errors", n_fe, 2);
    chk("sync9.frame_starts", n_fs, 6);
    chk("sync9.locked", 32'(locked_o), 0);
    send_sync(10);
    send_body(4'hA, -1, 0, 0);
    send_sync(10);
    send_body(4'hA, -1, 0, 0);
    settle();
    chk("sync.relocked", 32'(locked_o), 1);
    chk("sync.sample_count", samp_q.size(), 59);
    send_sync(11);
    settle();
    chk("sync11.errors", n_fe, 3);
    chk("sync11.frame_starts", n_fs, 8);
    chk("sync11.locked", 32'(locked_o), 0);
    send_sync(9);
    settle();
    chk("hunt9.frame_starts", n_fs, 8);
    chk("hunt9.errors", n_fe, 3);
    send_sync(10);
    settle();
    chk("hunt10.frame_starts", n_fs, 9);
    send_body(4'hA, -1, 0, 0);

    // valid_i dropped mid-channel 5
    send_sync(10);
    settle();
    chk("vdrop.lock_at_fs", 32'(lock_fs[9]), 1);
    send_body(4'hA, 5, 2, 7);
    settle();
    chk("vdrop.errors", n_fe, 4);
    chk("vdrop.locked", 32'(locked_o), 0);
    chk("vdrop.sample_count", samp_q.size(), 72);
    chk_samples(67, 5);
    // valid_i low in hunt clears the zero run without an error
    for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    settle();
    chk("hunt_vlow.frame_starts", n_fs, 10);
    chk("hunt_vlow.errors", n_fe, 4);
    send_sync(10);
    send_body(4'hA, -1, 0, 0);
    settle();
    chk("hunt_vlow.relock_samples", samp_q.size(), 80);

    // Asynchronous reset mid-channel 2
    send_sync(10);
    send_body(4'h5, 2, 3, 12);
    settle();
    chk("rst.pre_locked", 32'(locked_o), 1);
    chk("rst.pre_user", 32'(user_bits_o), 32'h5);
    chk("rst.pre_samples", samp_q.size(), 82);
    @(posedge clk_x4_i);
    #3;
    rst_i = 1'b1;
    #1;
    chk_zero("rst_mid");
    @(posedge clk_x4_i);
    #1;
    rst_i = 1'b0;
    chk("rst.no_sample", samp_q.size(), 82);
    send_sync(10);
    send_body(4'hA, -1, 0, 0);
    settle();
    chk("rst.frame_starts", n_fs, 13);
    chk("rst.errors", n_fe, 4);
    chk("rst.sample_count", samp_q.size(), 90);
    chk("rst.first_sample", 32'(samp_q[82]), 32'(exp_samp(0)));
    chk("rst.user_bits", 32'(user_bits_o), 32'hA);

`ifdef ADAT_ERR_COUNT_EN
    // Error counter
    @(posedge clk_x4_i);
    #3;
    rst_i = 1'b1;
    @(posedge clk_x4_i);
    #1;
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_sync(10);
      send_bit(1'b0, 1'b0);
    end
    settle();
    chk("errcnt.three", 32'(err_count_o), 3);
    force dut.err_cnt = 16'hFFFF;
    @(posedge clk_x4_i);
    #1;
    release dut.err_cnt;
    send_sync(10);
    send_bit(1'b0, 1'b0);
    settle();
    chk("errcnt.saturate", 32'(err_count_o), 32'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
